// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network training sequencer:
// state codes and layer-size helpers used at elaboration time.
package nn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd3,
        ST_SAVE = 3'd4,
        ST_DONE = 3'd5
    } nn_state_e;

    // Upper bound on layers the helpers accept; LR is widened to this size.
    localparam int MAX_L = 16;

    function automatic int layer_size(input logic [32*MAX_L-1:0] lr, input int l);
        return int'(lr[32*l +: 32]);
    endfunction

    // Weights plus one bias per neuron, summed over all non-input layers.
    function automatic int coef_total(input logic [32*MAX_L-1:0] lr, input int ltot);
        int s;
        s = 0;
        for (int l = 1; l < ltot; l++) begin
            s = s + layer_size(lr, l) * (layer_size(lr, l - 1) + 1);
        end
        return s;
    endfunction

endpackage

// File: rtl/nn_lat_pipe.sv
// Fixed-depth delay of {valid, index} matching node-memory read latency,
// so the coefficient strobe lines up with returning read data.
module nn_lat_pipe #(
    parameter int LAT = 1,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_idx,
    output logic         out_valid,
    output logic [W-1:0] out_idx
);

    logic [LAT-1:0] vld_q;
    logic [LAT-1:0] vld_d;
    logic [W-1:0]   idx_q [LAT];
    logic [W-1:0]   idx_d [LAT];

    always_comb begin
        vld_d[0] = in_valid & ~flush;
        idx_d[0] = in_idx;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1] & ~flush;
            idx_d[i] = idx_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < LAT; i++) begin
                idx_q[i] <= idx_d[i];
            end
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out_idx   = idx_q[LAT-1];

endmodule

// File: rtl/nn_train_sequencer.sv
// Training/inference sequencer: coefficient load, batch streaming, write-back.
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | read coefficients from node memory into layer registers
//   RUN   | stream input groups, commit one result per group
//   SAVE  | write updated coefficients back (training only)
//   DONE  | one-cycle completion pulse
module nn_train_sequencer
    import nn_pkg::*;
#(
    parameter int               LTOT    = 3,
    parameter logic [32*LTOT-1:0] LR    = {32'd1, 32'd2, 32'd2},
    parameter int               A       = 10,
    parameter int               N       = 16,
    parameter int               NCOEF   = 9,
    parameter int               T0      = 10,
    parameter int               MEM_LAT = 1,
    parameter int               CW      = $clog2(NCOEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          mode,
    input  logic [N-1:0]  batch,
    input  logic [15:0]   max_it,
    output logic          busy,
    output logic          done,
    output logic [2:0]    state,
    output logic [15:0]   iter,
    output logic [A-1:0]  x_addr,
    output logic [A-1:0]  y_addr,
    output logic [A-1:0]  t_addr,
    output logic [A-1:0]  nd_addr,
    output logic          e_x,
    output logic          e_nd,
    output logic          in_we,
    output logic          c_en,
    output logic [CW-1:0] c_idx,
    output logic          y_we,
    output logic          bp_we,
    output logic          sv_en,
    output logic          nd_we
);

    localparam logic [32*MAX_L-1:0] LR_EXT = (32*MAX_L)'(LR);
    localparam int                  SX     = layer_size(LR_EXT, 0);
    localparam int                  KW     = CW + 4;
    localparam logic [KW-1:0] LOAD_LAST = KW'(NCOEF + MEM_LAT - 1);
    localparam logic [KW-1:0] NC_K      = KW'(NCOEF);
    localparam logic [A-1:0]  ND_LAST   = A'(NCOEF - 1);
    localparam logic [A-1:0]  T0_A      = A'(T0);
    localparam logic [15:0]   SX_S      = 16'(SX);

    if (coef_total(LR_EXT, LTOT) != NCOEF) begin : g_bad_ncoef
        $error("NCOEF does not match the coefficient count implied by LR");
    end
    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
        $error("MEM_LAT must be in 1..4");
    end

    nn_state_e     state_q, state_d;
    logic          mode_q, mode_d;
    logic [N-1:0]  batch_q, batch_d;
    logic [15:0]   max_it_q, max_it_d;
    logic [15:0]   iter_q, iter_d;
    logic [KW-1:0] cnt_q, cnt_d;
    logic [15:0]   sub_q, sub_d;
    logic [N-1:0]  grp_q, grp_d;
    logic [A-1:0]  x_addr_q, x_addr_d;
    logic [A-1:0]  y_addr_q, y_addr_d;
    logic [A-1:0]  t_addr_q, t_addr_d;
    logic [A-1:0]  nd_addr_q, nd_addr_d;
    logic          e_x_q, e_x_d;
    logic          e_nd_q, e_nd_d;
    logic          in_we_q, in_we_d;
    logic          y_we_q, y_we_d;
    logic          bp_we_q, bp_we_d;
    logic          sv_en_q, sv_en_d;
    logic          nd_we_q, nd_we_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          go_load, go_run, go_save;
    logic          pipe_vld;
    logic [CW-1:0] pipe_idx;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        batch_d   = batch_q;
        max_it_d  = max_it_q;
        iter_d    = iter_q;
        cnt_d     = cnt_q;
        sub_d     = sub_q;
        grp_d     = grp_q;
        x_addr_d  = x_addr_q;
        y_addr_d  = y_addr_q;
        t_addr_d  = t_addr_q;
        nd_addr_d = nd_addr_q;
        e_x_d     = 1'b0;
        e_nd_d    = 1'b0;
        in_we_d   = 1'b0;
        y_we_d    = 1'b0;
        bp_we_d   = 1'b0;
        sv_en_d   = 1'b0;
        nd_we_d   = 1'b0;
        go_load   = 1'b0;
        go_run    = 1'b0;
        go_save   = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_d   = mode;
                        batch_d  = batch;
                        max_it_d = max_it;
                        if (mode && max_it == 16'd0) begin
                            state_d = ST_DONE;
                        end else begin
                            iter_d  = 16'd0;
                            go_load = 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    // Issue phase covers NCOEF cycles; the tail waits for read data.
                    if (cnt_q == LOAD_LAST) begin
                        if (batch_q == '0) begin
                            if (mode_q) go_save = 1'b1;
                            else        state_d = ST_DONE;
                        end else begin
                            go_run = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d < NC_K) begin
                            nd_addr_d = A'(cnt_d);
                            e_nd_d    = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (in_we_q) x_addr_d = x_addr_q + 1'b1;
                    if (sub_q == SX_S) begin
                        y_addr_d = y_addr_q + 1'b1;
                        t_addr_d = t_addr_q + 1'b1;
                        if (grp_q + 1'b1 == batch_q) begin
                            if (mode_q) go_save = 1'b1;
                            else        state_d = ST_DONE;
                        end else begin
                            grp_d   = grp_q + 1'b1;
                            sub_d   = 16'd0;
                            e_x_d   = 1'b1;
                            in_we_d = 1'b1;
                        end
                    end else begin
                        sub_d = sub_q + 16'd1;
                        if (sub_d == SX_S) begin
                            y_we_d  = ~mode_q;
                            bp_we_d = mode_q;
                        end else begin
                            e_x_d   = 1'b1;
                            in_we_d = 1'b1;
                        end
                    end
                end
                ST_SAVE: begin
                    if (nd_addr_q == ND_LAST) begin
                        iter_d = iter_q + 16'd1;
                        if (iter_d == max_it_q) state_d = ST_DONE;
                        else                    go_load = 1'b1;
                    end else begin
                        nd_addr_d = nd_addr_q + 1'b1;
                        sv_en_d   = 1'b1;
                        nd_we_d   = 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase

            if (go_load) begin
                state_d   = ST_LOAD;
                cnt_d     = '0;
                nd_addr_d = '0;
                e_nd_d    = 1'b1;
                x_addr_d  = '0;
                y_addr_d  = '0;
                t_addr_d  = T0_A;
            end
            if (go_run) begin
                state_d  = ST_RUN;
                sub_d    = 16'd0;
                grp_d    = '0;
                x_addr_d = '0;
                y_addr_d = '0;
                t_addr_d = T0_A;
                e_x_d    = 1'b1;
                in_we_d  = 1'b1;
            end
            if (go_save) begin
                state_d   = ST_SAVE;
                nd_addr_d = '0;
                sv_en_d   = 1'b1;
                nd_we_d   = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
            batch_q   <= '0;
            max_it_q  <= 16'd0;
            iter_q    <= 16'd0;
            cnt_q     <= '0;
            sub_q     <= 16'd0;
            grp_q     <= '0;
            x_addr_q  <= '0;
            y_addr_q  <= '0;
            t_addr_q  <= T0_A;
            nd_addr_q <= '0;
            e_x_q     <= 1'b0;
            e_nd_q    <= 1'b0;
            in_we_q   <= 1'b0;
            y_we_q    <= 1'b0;
            bp_we_q   <= 1'b0;
            sv_en_q   <= 1'b0;
            nd_we_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            batch_q   <= batch_d;
            max_it_q  <= max_it_d;
            iter_q    <= iter_d;
            cnt_q     <= cnt_d;
            sub_q     <= sub_d;
            grp_q     <= grp_d;
            x_addr_q  <= x_addr_d;
            y_addr_q  <= y_addr_d;
            t_addr_q  <= t_addr_d;
            nd_addr_q <= nd_addr_d;
            e_x_q     <= e_x_d;
            e_nd_q    <= e_nd_d;
            in_we_q   <= in_we_d;
            y_we_q    <= y_we_d;
            bp_we_q   <= bp_we_d;
            sv_en_q   <= sv_en_d;
            nd_we_q   <= nd_we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    nn_lat_pipe #(
        .LAT (MEM_LAT),
        .W   (CW)
    ) u_lat_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .in_valid  (e_nd_q),
        .in_idx    (nd_addr_q[CW-1:0]),
        .out_valid (pipe_vld),
        .out_idx   (pipe_idx)
    );

    assign state   = state_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign iter    = iter_q;
    assign x_addr  = x_addr_q;
    assign y_addr  = y_addr_q;
    assign t_addr  = t_addr_q;
    assign nd_addr = nd_addr_q;
    assign e_x     = e_x_q;
    assign e_nd    = e_nd_q;
    assign in_we   = in_we_q;
    assign y_we    = y_we_q;
    assign bp_we   = bp_we_q;
    assign sv_en   = sv_en_q;
    assign nd_we   = nd_we_q;
    assign c_en    = pipe_vld;
    // Write-back reuses the coefficient index bus to select the update register.
    assign c_idx   = sv_en_q ? nd_addr_q[CW-1:0] : pipe_idx;

endmodule
